// File: rtl/if_prefetch_queue.sv
// ============================================================================
// if_prefetch_queue
// ----------------------------------------------------------------------------
// Instruction-fetch front end that sits directly upstream of the IF/ID
// register. It owns the fetch PC and reads the combinational instruction
// memory in every cycle that the queue has room. Fetched {pc, instr} pairs
// are buffered in a DEPTH-entry FIFO, so an ID stall does not block fetch.
// A flush (taken branch/jump) empties the FIFO. Fetch then restarts at the
// redirect target.
//
// Optional feature (compile-time macro IFQ_BUBBLE_CNT_EN):
//   defined     -> stat_bubbles counts the cycles in which ID is ready but the
//                  queue has nothing to give (~id_keep & ~if_valid & ~flush).
//                  The count wraps at 2^32 and is cleared only by reset.
//   not defined -> stat_bubbles is tied to zero and no counter flops exist.
//
// Parameters:
//   DEPTH    FIFO entries (power of 2, >= 2)
//   AW       instruction-memory word-address width
//   RESET_PC first fetch address after reset
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   imem_addr    out  word address to instruction memory (fetch_pc[AW+1:2])
//   imem_rdata   in   instruction at imem_addr, valid in the same cycle
//   flush        in   discard the queue and reload fetch_pc from redirect_pc
//   redirect_pc  in   new fetch PC, sampled only when flush=1 (bits [1:0] ignored)
//   id_keep      in   ID stall: hold the head entry, do not pop
//   if_valid     out  head entry valid (queue non-empty)
//   if_pc        out  PC of the head entry, 0 when the queue is empty
//   if_instr     out  instruction of the head entry, 0 (NOP) when the queue is empty
//   q_count      out  current occupancy (0..DEPTH)
//   stat_bubbles out  bubble counter (see the optional feature above)
// ============================================================================
module if_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          AW       = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [AW-1:0]            imem_addr,
   input  logic [31:0]              imem_rdata,
   input  logic                     flush,
   input  logic [31:0]              redirect_pc,
   input  logic                     id_keep,
   output logic                     if_valid,
   output logic [31:0]              if_pc,
   output logic [31:0]              if_instr,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic [31:0]              stat_bubbles
);

   localparam int PW = $clog2(DEPTH);   // pointer width
   localparam int CW = PW + 1;          // count width (must be able to hold DEPTH)

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [31:0]   r_fetch_pc;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   // The storage is split into pc and instr halves. Both halves are written
   // together, so they always describe the same entry.
   logic [31:0]   r_mem_pc    [DEPTH];
   logic [31:0]   r_mem_instr [DEPTH];

   // -------------------------------------------------------------------------
   // Control
   // -------------------------------------------------------------------------
   logic w_nonempty;
   logic w_full;
   logic w_push;
   logic w_pop;

   assign w_nonempty = (r_count != '0);
   // "full" is taken from the count before the edge. A full queue therefore
   // does not refill the slot that it frees in the same cycle.
   assign w_full     = (r_count == CW'(DEPTH));
   // A flush overrides both push and pop. id_keep has no effect during a flush.
   assign w_push     = ~w_full & ~flush;
   assign w_pop      = w_nonempty & ~id_keep & ~flush;

   // The low two bits of redirect_pc are dropped, because fetch is always
   // word aligned.
   logic [1:0] w_unused_redirect_lsbs;
   assign w_unused_redirect_lsbs = redirect_pc[1:0];

   // -------------------------------------------------------------------------
   // Fetch PC
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= RESET_PC;
      end else if (flush) begin
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   assign imem_addr = r_fetch_pc[AW+1:2];

   // -------------------------------------------------------------------------
   // Pointers and occupancy
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // DEPTH is a power of 2, so the natural pointer overflow is the
         // modulo-DEPTH wrap.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Storage: one write-enable per entry. The entries have no reset, because
   // the pointers and count alone define which entries are valid.
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic w_we;
         assign w_we = w_push && (r_wr_ptr == PW'(gi));

         always_ff @(posedge clk) begin
            if (w_we) begin
               r_mem_pc[gi]    <= r_fetch_pc;
               r_mem_instr[gi] <= imem_rdata;
            end
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Head outputs. They are driven combinationally from the head entry, so
   // an instruction fetched in cycle N is visible in cycle N+1. The outputs
   // are gated to zero when the queue is empty, which also makes them drop
   // as soon as reset is asserted.
   // -------------------------------------------------------------------------
   assign if_valid = w_nonempty;
   assign if_pc    = w_nonempty ? r_mem_pc[r_rd_ptr]    : 32'h0;
   assign if_instr = w_nonempty ? r_mem_instr[r_rd_ptr] : 32'h0;
   assign q_count  = r_count;

   // -------------------------------------------------------------------------
   // Bubble statistics
   // -------------------------------------------------------------------------
`ifdef IFQ_BUBBLE_CNT_EN
   logic [31:0] r_bubbles;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bubbles <= '0;
      end else if (~id_keep & ~w_nonempty & ~flush) begin
         r_bubbles <= r_bubbles + 32'd1;
      end
   end

   assign stat_bubbles = r_bubbles;
`else
   assign stat_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ============================================================================
// tb_if_prefetch_queue
// ----------------------------------------------------------------------------
// Self-checking bench for if_prefetch_queue. The reference model is a SV
// queue of {pc, instr} pairs plus a fetch PC, updated once per clock from the
// behavioural rules (flush clears, pop from the front, push to the back when
// the queue was not full). The instruction memory is a pure function of the
// word address.
// ============================================================================
module tb_if_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          AW       = 10;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam int          CW       = $clog2(DEPTH) + 1;

   logic             clk;
   logic             reset;
   logic [AW-1:0]    imem_addr;
   logic [31:0]      imem_rdata;
   logic             flush;
   logic [31:0]      redirect_pc;
   logic             id_keep;
   logic             if_valid;
   logic [31:0]      if_pc;
   logic [31:0]      if_instr;
   logic [CW-1:0]    q_count;
   logic [31:0]      stat_bubbles;

   int n_total = 0;
   int n_bad   = 0;

   // -------------------------------------------------------------------------
   // Instruction memory: every word address holds a distinct pattern
   // -------------------------------------------------------------------------
   function automatic logic [31:0] imem_fn(input logic [AW-1:0] a);
      return 32'h1300_0013 ^ (32'(a) * 32'h9E37_79B1);
   endfunction

   assign imem_rdata = imem_fn(imem_addr);

   if_prefetch_queue #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .id_keep     (id_keep),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .q_count     (q_count),
      .stat_bubbles(stat_bubbles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // -------------------------------------------------------------------------
   // Checking
   // -------------------------------------------------------------------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Reference model
   // -------------------------------------------------------------------------
   logic [63:0] mdl_q[$];
   logic [31:0] mdl_pc;
   logic [31:0] mdl_bubbles;

   task automatic model_reset();
      mdl_q.delete();
      mdl_pc      = RESET_PC;
      mdl_bubbles = 32'h0;
   endtask

   // Compare all DUT outputs with the current model state.
   task automatic check_outputs();
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      exp_pc    = 32'h0;
      exp_instr = 32'h0;
      if (mdl_q.size() != 0) begin
         exp_pc    = mdl_q[0][63:32];
         exp_instr = mdl_q[0][31:0];
      end
      chk("if_valid",  64'(if_valid),  64'(mdl_q.size() != 0));
      chk("if_pc",     64'(if_pc),     64'(exp_pc));
      chk("if_instr",  64'(if_instr),  64'(exp_instr));
      chk("q_count",   64'(q_count),   64'(mdl_q.size()));
      chk("imem_addr", 64'(imem_addr), 64'(mdl_pc[AW+1:2]));
`ifdef IFQ_BUBBLE_CNT_EN
      chk("bubbles",   64'(stat_bubbles), 64'(mdl_bubbles));
`else
      chk("bubbles",   64'(stat_bubbles), 64'h0);
`endif
   endtask

   // Advance the model across one clock edge, using the inputs just applied.
   task automatic model_advance();
      int  occ;
      logic [63:0] popped;
      occ = mdl_q.size();
      if (!id_keep && occ == 0 && !flush)
         mdl_bubbles = mdl_bubbles + 32'd1;
      if (flush) begin
         mdl_q.delete();
         mdl_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (occ > 0 && !id_keep) begin
            popped = mdl_q.pop_front();
            $display("pop  pc=%08h instr=%08h", popped[63:32], popped[31:0]);
         end
         if (occ < DEPTH) begin
            mdl_q.push_back({mdl_pc, imem_fn(mdl_pc[AW+1:2])});
            mdl_pc = mdl_pc + 32'd4;
         end
      end
   endtask

   // Called at a negedge: check the current state, then apply the inputs for
   // the coming edge.
   task automatic do_cycle(input logic keep, input logic fl, input logic [31:0] rp);
      check_outputs();
      id_keep     = keep;
      flush       = fl;
      redirect_pc = rp;
      model_advance();
   endtask

   task automatic step(input logic keep, input logic fl, input logic [31:0] rp);
      @(negedge clk);
      do_cycle(keep, fl, rp);
   endtask

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      reset       = 1'b0;
      flush       = 1'b0;
      id_keep     = 1'b0;
      redirect_pc = 32'h0;
      model_reset();

      repeat (2) @(negedge clk);
      // Outputs are checked while reset is still held.
      chk("rst_valid", 64'(if_valid), 64'h0);
      chk("rst_count", 64'(q_count),  64'h0);
      chk("rst_addr",  64'(imem_addr), 64'(RESET_PC[AW+1:2]));
      reset = 1'b1;

      // Scenario 1: streaming with no stall.
      do_cycle(1'b0, 1'b0, 32'h0);
      repeat (5) step(1'b0, 1'b0, 32'h0);

      // Scenario 2: hold ID, so the queue fills and fetch freezes.
      repeat (6) step(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("full_count", 64'(q_count), 64'(DEPTH));
      do_cycle(1'b1, 1'b0, 32'h0);

      // Scenario 3: release the stall while the queue is full.
      repeat (6) step(1'b0, 1'b0, 32'h0);

      // Scenario 4: flush with entries queued.
      repeat (3) step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_3040);
      step(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("redir_pc", 64'(if_pc), 64'h3040);
      do_cycle(1'b0, 1'b0, 32'h0);

      // Scenario 5: a misaligned redirect target.
      step(1'b0, 1'b1, 32'h0000_3043);
      repeat (3) step(1'b0, 1'b0, 32'h0);

      // Scenario 6: bubbles during the empty cycles that follow a flush.
      step(1'b1, 1'b1, 32'h0000_3100);
      repeat (5) step(1'b0, 1'b1, 32'h0000_3200);
      repeat (4) step(1'b0, 1'b0, 32'h0);

      // Scenario 7: asynchronous reset with 2 entries queued.
      step(1'b1, 1'b1, 32'h0000_3300);
      repeat (2) step(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check_outputs();
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", 64'(if_valid),     64'h0);
      chk("arst_pc",    64'(if_pc),        64'h0);
      chk("arst_instr", 64'(if_instr),     64'h0);
      chk("arst_count", 64'(q_count),      64'h0);
      chk("arst_bub",   64'(stat_bubbles), 64'h0);
      chk("arst_addr",  64'(imem_addr),    64'(RESET_PC[AW+1:2]));
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      do_cycle(1'b0, 1'b0, 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic        k;
         logic        f;
         logic [31:0] r;
         k = ($urandom_range(0, 99) < 45);
         f = ($urandom_range(0, 99) < 6);
         r = RESET_PC + 32'($urandom_range(0, 1023));
         step(k, f, r);
      end
      @(negedge clk);
      check_outputs();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
